bht_predictor: RTL

BHT_PREDICTOR -- requirements
Module: bht_predictor

---
 rtl/bht_predictor.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bht_predictor.sv
// Bimodal/gshare branch predictor: 2-bit counters indexed by PC xor global history.
// Table is swept to weak-not-taken after reset; predictions are registered (latency 1).
module bht_predictor #(
  parameter int INDEX_BITS  = 10,
  parameter int GHR_BITS    = 8,
  parameter bit JAL_PREDICT = 1
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  pred_req_in,
  input  logic [31:0]           pc_addr_in,
  input  logic [31:0]           ins_data_in,
  input  logic                  feedback_enable_in,
  input  logic                  taken_branch_in,
  input  logic [INDEX_BITS-1:0] fb_index_in,
  output logic                  ready_out,
  output logic                  pred_valid_out,
  output logic                  taken_pred_out,
  output logic [31:0]           pred_pc_out,
  output logic [INDEX_BITS-1:0] pred_index_out
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int GW = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t                state_q, state_d;
  logic [INDEX_BITS-1:0] sweep_q, sweep_d;
  logic [GW-1:0]         ghr_q, ghr_d;
  logic [1:0]            cnt_q [ENTRIES];

  logic                  tbl_we;
  logic [INDEX_BITS-1:0] tbl_wa;
  logic [1:0]            tbl_wd;

  logic                  valid_q, valid_d;
  logic                  taken_q, taken_d;
  logic [31:0]           tgt_q, tgt_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;

  logic                  ready;
  logic [INDEX_BITS-1:0] ghr_ext;
  logic [INDEX_BITS-1:0] rd_idx;
  logic [1:0]            rd_cnt;
  logic [1:0]            fb_cnt;
  logic [31:0]           b_imm;
  logic [31:0]           j_imm;
  logic [4:0]            opcode;
  logic                  unused_ins;

  assign ready      = (state_q == S_READY);
  assign ready_out  = ready;
  assign opcode     = ins_data_in[6:2];
  assign unused_ins = ^ins_data_in[1:0];

  assign ghr_ext = (GHR_BITS > 0) ? INDEX_BITS'(ghr_q) : '0;
  assign rd_idx  = pc_addr_in[INDEX_BITS+1:2] ^ ghr_ext;
  assign rd_cnt  = cnt_q[rd_idx];
  assign fb_cnt  = cnt_q[fb_index_in];

  assign b_imm = {{19{ins_data_in[31]}}, ins_data_in[31],
                  ins_data_in[7], ins_data_in[30:25],
                  ins_data_in[11:8], 1'b0};
  assign j_imm = {{11{ins_data_in[31]}}, ins_data_in[31],
                  ins_data_in[19:12], ins_data_in[20],
                  ins_data_in[30:21], 1'b0};

  // Sweep and feedback share the single table write port.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ghr_d   = ghr_q;
    tbl_we  = 1'b0;
    tbl_wa  = sweep_q;
    tbl_wd  = 2'b01;
    unique case (state_q)
      S_INIT: begin
        tbl_we  = 1'b1;
        sweep_d = sweep_q + INDEX_BITS'(1);
        if (sweep_q == '1) state_d = S_READY;
      end
      S_READY: begin
        if (feedback_enable_in) begin
          tbl_we = 1'b1;
          tbl_wa = fb_index_in;
          if (taken_branch_in)
            tbl_wd = (fb_cnt == 2'b11) ? 2'b11 : fb_cnt + 2'd1;
          else
            tbl_wd = (fb_cnt == 2'b00) ? 2'b00 : fb_cnt - 2'd1;
          if (GHR_BITS > 0) ghr_d = GW'({ghr_q, taken_branch_in});
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    taken_d = 1'b0;
    tgt_d   = '0;
    idx_d   = '0;
    if (pred_req_in && ready) begin
      valid_d = 1'b1;
      idx_d   = rd_idx;
      unique case (1'b1)
        (opcode == OP_BRANCH): begin
          taken_d = rd_cnt[1];
          tgt_d   = rd_cnt[1] ? pc_addr_in + b_imm : '0;
        end
        (opcode == OP_JAL && JAL_PREDICT): begin
          taken_d = 1'b1;
          tgt_d   = pc_addr_in + j_imm;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= S_INIT;
      sweep_q <= '0;
      ghr_q   <= '0;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      tgt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
      valid_q <= valid_d;
      taken_q <= taken_d;
      tgt_q   <= tgt_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in && tbl_we) cnt_q[tbl_wa] <= tbl_wd;
  end

  assign pred_valid_out = valid_q;
  assign taken_pred_out = taken_q;
  assign pred_pc_out    = tgt_q;
  assign pred_index_out = idx_q;

endmodule
